dsi_crc_engine: RTL and testbench
=================================

Name: dsi_crc_engine

Overview:
Parametrised successor to the fixed 64-bit video CRC block. It computes the DSI long-packet payload checksum: CRC-16/CCITT, reflected polynomial 0x8408, seed SEED, LSB-first, no final XOR. Data arrives as BYTES lanes per beat, with a per-byte keep mask and explicit packet framing. It sits between the MIPI formatter's payload mux and the packet footer insertion, and is reused on the loopback receive path for checking.

Parameters:
BYTES, 8, payload bytes per beat; legal values 1..16. Byte k is data[8k+7:8k]; byte 0 is first on the wire.
SEED, 16'hFFFF, CRC preset value loaded at start, at reset, and at implicit start.

Ports:
clk  in  1  system clock
reset  in  1  synchronous, active-high
start  in  1  preset accumulator to SEED; begin packet
en  in  1  beat valid; fold kept bytes of data
last  in  1  qualifies en; final beat of packet
keep  in  BYTES  byte-valid mask; must be contiguous from bit 0
data  in  8*BYTES  payload bytes, DSI byte order
crc  out  16  running/final CRC, registered
crc_valid  out  1  one-cycle pulse, crc is final
busy  out  1  packet in progress

Behaviour:
- One clock; reset is synchronous and active-high.
- Reset: crc=SEED, crc_valid=0, busy=0. Applies mid-packet: the partial packet is discarded and no crc_valid is issued.
- States: IDLE (busy=0) and ACCUM (busy=1).
- start in IDLE or ACCUM: accumulator := SEED, go to ACCUM. Restarting mid-packet abandons the old packet silently.
- start && en in the same cycle: seed first, then fold the beat into the seed, all in one cycle.
- en in IDLE without start: implicit start. The beat is folded into SEED and the block enters ACCUM.
- Fold: bytes 0..n-1 are processed in ascending order, each LSB-first, where n = popcount(keep).
  - keep=0 with en: accumulator unchanged.
  - Non-contiguous keep: only the bytes below the lowest zero bit are folded.
- Fold is a single-cycle combinational unroll of up to BYTES bytes. crc updates on the clock edge after the en cycle (latency 1).
- en && last: crc_valid=1 in the next cycle, with crc equal to the final value. Then go to IDLE.
- crc holds its value in IDLE until the next start, en, or reset.
- last without en: ignored.
- en during the crc_valid cycle is legal and starts the next packet via implicit start. crc_valid still pulses for the previous packet.
- Back-to-back packets are supported: the last beat of packet A may be followed on the next cycle by the first beat of packet B, with zero bubbles.
- Empty packet (start, then en&&last with keep=0): crc=SEED (0xFFFF), crc_valid pulses.
- keep=all-ones with BYTES=8 is bit-identical to the legacy 64-bit block.

Optional Feature:
Macro: DSI_CRC_CHECK_EN.
- Defined:
  - Adds input rx_crc[15:0], sampled on the en&&last cycle. rx_crc[7:0] is the first received CRC byte.
  - Adds outputs crc_ok and crc_err, both registered and asserted only in the crc_valid cycle.
  - crc_ok=(final crc==rx_crc); crc_err is its complement.
  - Adds a saturating 16-bit err_count output that increments on each crc_err and clears on reset.
- Not defined: these ports and this logic are absent; behaviour is otherwise identical.

Test Plan:
- BYTES=8, start; three full beats FF0000001EF01EC7 / 4F8278C582E08C70 / D23C78E9FF000001 (byte 0 listed first), last on beat 3 -> crc_valid one cycle after beat 3, crc=0xE569.
- BYTES=8, beats FF000002B9DCF372 / BBD4B85AC875C27C / 81F805DFFF000001, immediately back-to-back after the first packet -> second crc_valid with crc=0x00F0, no bubble; first result 0xE569 still correct.
- BYTES=8, first-packet bytes split 8/8/4/4 with keep=FF,FF,0F,0F -> crc=0xE569. Repeat with BYTES=4 (six full beats) -> 0xE569.
- start, then en&&last with keep=0 -> crc_valid, crc=0xFFFF. Also: en without start from IDLE over the first packet -> 0xE569.
- Reset asserted after beat 2 of the first packet, then the packet is resent -> no crc_valid during the aborted packet, busy=0 after reset, final crc=0xE569.
- DSI_CRC_CHECK_EN: rx_crc=0xE569 -> crc_ok=1, crc_err=0. rx_crc=0xE568 -> crc_err=1, err_count increments 0->1.

Source files
------------

// File: rtl/dsi_crc_engine.sv
// DSI long-packet payload CRC (CRC-16/CCITT, reflected 0x8408, LSB-first) over BYTES lanes per beat.
// Optional receive-side checker enabled by defining DSI_CRC_CHECK_EN.
module dsi_crc_engine #(
  parameter int unsigned BYTES = 8,
  parameter logic [15:0] SEED  = 16'hFFFF
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start,
  input  logic                 en,
  input  logic                 last,
  input  logic [BYTES-1:0]     keep,
  input  logic [8*BYTES-1:0]   data,
`ifdef DSI_CRC_CHECK_EN
  input  logic [15:0]          rx_crc,
  output logic                 crc_ok,
  output logic                 crc_err,
  output logic [15:0]          err_count,
`endif
  output logic [15:0]          crc,
  output logic                 crc_valid,
  output logic                 busy
);

  localparam logic [15:0] POLY = 16'h8408;

  typedef enum logic {IDLE, ACCUM} state_t;

  state_t      state_q;
  state_t      state_d;
  logic [15:0] crc_d;
  logic        crc_valid_d;
  logic        busy_d;
  logic        preset;
  logic [15:0] crc_base;

  // Fold the contiguous run of kept bytes starting at byte 0, each byte LSB-first.
  function automatic logic [15:0] fold(input logic [15:0]        c_in,
                                       input logic [BYTES-1:0]   k,
                                       input logic [8*BYTES-1:0] d);
    logic [15:0] c;
    logic        live;
    c    = c_in;
    live = 1'b1;
    for (int i = 0; i < int'(BYTES); i++) begin
      live = live & k[i];
      if (live) begin
        c = c ^ {8'h00, d[8*i +: 8]};
        for (int b = 0; b < 8; b++) begin
          c = c[0] ? ((c >> 1) ^ POLY) : (c >> 1);
        end
      end
    end
    return c;
  endfunction

  // State and output registers
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= IDLE;
      crc       <= SEED;
      crc_valid <= 1'b0;
      busy      <= 1'b0;
    end else begin
      state_q   <= state_d;
      crc       <= crc_d;
      crc_valid <= crc_valid_d;
      busy      <= busy_d;
    end
  end

  // Next-state logic; a final beat always returns to IDLE, even when it also starts the packet
  always_comb begin
    state_d = state_q;
    if (en && last) begin
      state_d = IDLE;
    end else if (start || en) begin
      state_d = ACCUM;
    end
  end

  // Output logic: explicit or implicit start presets the accumulator before folding
  always_comb begin
    preset      = start || (en && (state_q == IDLE));
    crc_base    = preset ? SEED : crc;
    crc_d       = crc_base;
    crc_valid_d = en && last;
    busy_d      = (state_d == ACCUM);
    if (en) begin
      crc_d = fold(crc_base, keep, data);
    end
  end

`ifdef DSI_CRC_CHECK_EN
  logic crc_ok_d;
  logic crc_err_d;

  always_comb begin
    crc_ok_d  = 1'b0;
    crc_err_d = 1'b0;
    if (en && last) begin
      crc_ok_d  = (crc_d == rx_crc);
      crc_err_d = (crc_d != rx_crc);
    end
  end

  // Checker flags align with crc_valid; error counter saturates
  always_ff @(posedge clk) begin
    if (reset) begin
      crc_ok    <= 1'b0;
      crc_err   <= 1'b0;
      err_count <= 16'h0000;
    end else begin
      crc_ok  <= crc_ok_d;
      crc_err <= crc_err_d;
      if (crc_err_d && (err_count != 16'hFFFF)) begin
        err_count <= err_count + 16'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_dsi_crc_engine.sv
// Directed bench for dsi_crc_engine: BYTES=8 and BYTES=4 instances, checker ports when DSI_CRC_CHECK_EN is defined.
module tb_dsi_crc_engine;

  logic        clk = 1'b0;
  logic        reset;
  logic        start8, en8, last8;
  logic [7:0]  keep8;
  logic [63:0] data8;
  logic [15:0] crc8;
  logic        valid8, busy8;
  logic        start4, en4, last4;
  logic [3:0]  keep4;
  logic [31:0] data4;
  logic [15:0] crc4;
  logic        valid4, busy4;
`ifdef DSI_CRC_CHECK_EN
  logic [15:0] rx8, rx4, errc8, errc4;
  logic        ok8, err8, ok4, err4;
`endif

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  dsi_crc_engine #(.BYTES(8), .SEED(16'hFFFF)) u_dut8 (
    .clk(clk), .reset(reset), .start(start8), .en(en8), .last(last8),
    .keep(keep8), .data(data8),
`ifdef DSI_CRC_CHECK_EN
    .rx_crc(rx8), .crc_ok(ok8), .crc_err(err8), .err_count(errc8),
`endif
    .crc(crc8), .crc_valid(valid8), .busy(busy8)
  );

  dsi_crc_engine #(.BYTES(4), .SEED(16'hFFFF)) u_dut4 (
    .clk(clk), .reset(reset), .start(start4), .en(en4), .last(last4),
    .keep(keep4), .data(data4),
`ifdef DSI_CRC_CHECK_EN
    .rx_crc(rx4), .crc_ok(ok4), .crc_err(err4), .err_count(errc4),
`endif
    .crc(crc4), .crc_valid(valid4), .busy(busy4)
  );

  // Byte 0 on the wire is the leftmost byte of the listed hex string
  function automatic logic [63:0] bs64(input logic [63:0] x);
    logic [63:0] r;
    for (int i = 0; i < 8; i++) r[8*i +: 8] = x[8*(7-i) +: 8];
    return r;
  endfunction

  function automatic logic [31:0] bs32(input logic [31:0] x);
    logic [31:0] r;
    for (int i = 0; i < 4; i++) r[8*i +: 8] = x[8*(3-i) +: 8];
    return r;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step8(input logic s, input logic e, input logic l,
                       input logic [7:0] k, input logic [63:0] d);
    start8 = s; en8 = e; last8 = l; keep8 = k; data8 = d;
    @(posedge clk); #1;
    start8 = 1'b0; en8 = 1'b0; last8 = 1'b0; keep8 = 8'h00; data8 = '0;
  endtask

  task automatic step4(input logic s, input logic e, input logic l,
                       input logic [3:0] k, input logic [31:0] d);
    start4 = s; en4 = e; last4 = l; keep4 = k; data4 = d;
    @(posedge clk); #1;
    start4 = 1'b0; en4 = 1'b0; last4 = 1'b0; keep4 = 4'h0; data4 = '0;
  endtask

  initial begin
    reset = 1'b1;
    start8 = 0; en8 = 0; last8 = 0; keep8 = 0; data8 = 0;
    start4 = 0; en4 = 0; last4 = 0; keep4 = 0; data4 = 0;
`ifdef DSI_CRC_CHECK_EN
    rx8 = 16'hE569; rx4 = 16'hE569;
`endif
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;

    check("reset_crc", 32'(crc8), 32'hFFFF);
    check("reset_valid", 32'(valid8), 32'h0);
    check("reset_busy", 32'(busy8), 32'h0);
    check("reset_crc4", 32'(crc4), 32'hFFFF);

    // Packet A (start with first beat), then packet B back-to-back via implicit start
    step8(1, 1, 0, 8'hFF, bs64(64'hFF0000001EF01EC7));
    check("a1_busy", 32'(busy8), 32'h1);
    check("a1_valid", 32'(valid8), 32'h0);
    step8(0, 1, 0, 8'hFF, bs64(64'h4F8278C582E08C70));
    check("a2_valid", 32'(valid8), 32'h0);
    step8(0, 1, 1, 8'hFF, bs64(64'hD23C78E9FF000001));
    check("a_valid", 32'(valid8), 32'h1);
    check("a_crc", 32'(crc8), 32'hE569);
    check("a_busy_after", 32'(busy8), 32'h0);
`ifdef DSI_CRC_CHECK_EN
    check("a_ok", 32'(ok8), 32'h1);
    check("a_err", 32'(err8), 32'h0);
    check("a_errcount", 32'(errc8), 32'h0);
    rx8 = 16'h00F0;
`endif
    step8(0, 1, 0, 8'hFF, bs64(64'hFF000002B9DCF372));
    check("b1_valid", 32'(valid8), 32'h0);
    check("b1_busy", 32'(busy8), 32'h1);
    step8(0, 1, 0, 8'hFF, bs64(64'hBBD4B85AC875C27C));
    step8(0, 1, 1, 8'hFF, bs64(64'h81F805DFFF000001));
    check("b_valid", 32'(valid8), 32'h1);
    check("b_crc", 32'(crc8), 32'h00F0);
    step8(0, 0, 1, 8'hFF, bs64(64'h0123456789ABCDEF));
    check("idle_valid", 32'(valid8), 32'h0);
    check("idle_hold_crc", 32'(crc8), 32'h00F0);
    check("idle_busy", 32'(busy8), 32'h0);

    // Split 8/8/4/4 with a separate start cycle and a mismatching rx_crc
`ifdef DSI_CRC_CHECK_EN
    rx8 = 16'hE568;
`endif
    step8(1, 0, 0, 8'h00, '0);
    check("split_start_crc", 32'(crc8), 32'hFFFF);
    check("split_start_busy", 32'(busy8), 32'h1);
    step8(0, 1, 0, 8'hFF, bs64(64'hFF0000001EF01EC7));
    step8(0, 1, 0, 8'hFF, bs64(64'h4F8278C582E08C70));
    step8(0, 1, 0, 8'h0F, bs64(64'hD23C78E9AAAAAAAA));
    step8(0, 1, 1, 8'h0F, bs64(64'hFF00000155555555));
    check("split_valid", 32'(valid8), 32'h1);
    check("split_crc", 32'(crc8), 32'hE569);
`ifdef DSI_CRC_CHECK_EN
    check("split_ok", 32'(ok8), 32'h0);
    check("split_err", 32'(err8), 32'h1);
    check("split_errcount", 32'(errc8), 32'h1);
    rx8 = 16'hE569;
`endif

    // Implicit start from IDLE with non-contiguous keep on beat 3 (only bytes 0..3 count)
    step8(0, 0, 0, 8'h00, '0);
    step8(0, 1, 0, 8'hFF, bs64(64'hFF0000001EF01EC7));
    check("impl_busy", 32'(busy8), 32'h1);
    step8(0, 1, 0, 8'hFF, bs64(64'h4F8278C582E08C70));
    step8(0, 1, 0, 8'hAF, bs64(64'hD23C78E912345678));
    step8(0, 1, 1, 8'h0F, bs64(64'hFF0000019ABCDEF0));
    check("impl_valid", 32'(valid8), 32'h1);
    check("impl_crc", 32'(crc8), 32'hE569);

    // Empty packet
`ifdef DSI_CRC_CHECK_EN
    rx8 = 16'hFFFF;
`endif
    step8(1, 0, 0, 8'h00, '0);
    step8(0, 1, 1, 8'h00, bs64(64'h1122334455667788));
    check("empty_valid", 32'(valid8), 32'h1);
    check("empty_crc", 32'(crc8), 32'hFFFF);

    // Reset mid-packet, then resend
`ifdef DSI_CRC_CHECK_EN
    rx8 = 16'hE569;
`endif
    step8(1, 1, 0, 8'hFF, bs64(64'hFF0000001EF01EC7));
    step8(0, 1, 0, 8'hFF, bs64(64'h4F8278C582E08C70));
    check("abort_valid", 32'(valid8), 32'h0);
    reset = 1'b1;
    step8(0, 0, 0, 8'h00, '0);
    reset = 1'b0;
    check("abort_busy", 32'(busy8), 32'h0);
    check("abort_crc", 32'(crc8), 32'hFFFF);
    check("abort_valid_rst", 32'(valid8), 32'h0);
`ifdef DSI_CRC_CHECK_EN
    check("abort_errcount", 32'(errc8), 32'h0);
`endif
    step8(0, 0, 0, 8'h00, '0);
    check("abort_idle_valid", 32'(valid8), 32'h0);
    step8(1, 1, 0, 8'hFF, bs64(64'hFF0000001EF01EC7));
    step8(0, 1, 0, 8'hFF, bs64(64'h4F8278C582E08C70));
    step8(0, 1, 1, 8'hFF, bs64(64'hD23C78E9FF000001));
    check("resend_valid", 32'(valid8), 32'h1);
    check("resend_crc", 32'(crc8), 32'hE569);

    // BYTES=4: six full beats
    step4(1, 1, 0, 4'hF, bs32(32'hFF000000));
    check("w4_busy", 32'(busy4), 32'h1);
    step4(0, 1, 0, 4'hF, bs32(32'h1EF01EC7));
    step4(0, 1, 0, 4'hF, bs32(32'h4F8278C5));
    step4(0, 1, 0, 4'hF, bs32(32'h82E08C70));
    step4(0, 1, 0, 4'hF, bs32(32'hD23C78E9));
    check("w4_midvalid", 32'(valid4), 32'h0);
    step4(0, 1, 1, 4'hF, bs32(32'hFF000001));
    check("w4_valid", 32'(valid4), 32'h1);
    check("w4_crc", 32'(crc4), 32'hE569);
`ifdef DSI_CRC_CHECK_EN
    check("w4_ok", 32'(ok4), 32'h1);
`endif
    step4(0, 0, 0, 4'h0, '0);
    check("w4_pulse_end", 32'(valid4), 32'h0);
    check("w4_busy_end", 32'(busy4), 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
